alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL expose these ports: clk, input, 1, sole clock, rising-edge.
REQ-002 The block SHALL expose: rst, input, 1, synchronous active-high reset.
REQ-003 The block SHALL expose: in_valid, input, 1, instruction/operands valid.
REQ-004 The block SHALL expose: in_ready, output, 1, block accepts the instruction this cycle.
REQ-005 The block SHALL expose: op, input, 6, MIPS opcode; funct, input, 6, R-type function; shamt, input, 5, shift amount; imm, input, 16, I-type immediate.
REQ-006 The block SHALL expose: rs_val, input, 32; rt_val, input, 32, register operands.
REQ-007 The block SHALL expose: out_valid, output, 1; out_ready, input, 1, result handshake.
REQ-008 The block SHALL expose: result, output, 32; zero, output, 1 (result==0); illegal, output, 1, undecodable instruction flag.
REQ-009 The block SHALL expose: alu_ctrl, output, 4, registered control code of the op in flight, for debug.

Function
REQ-010 Control encoding SHALL be: 0000 add, 0001 sub, 0010 shift-left (b<<a), 0011 or, 0100 and, 0101 unsigned less-than, 0110 signed less-than, 0111 xor, 1111 none (result 0).
REQ-011 R-type (op=000000) decode SHALL be: funct 100000/100001 add; 100010/100011 sub; 000000 shift-left with a=zero-extended shamt, b=rt_val; 100101 or; 100100 and; 101010 signed slt; 101011 unsigned slt; 100110 xor; all other funct 1111.
REQ-012 I-type decode SHALL be: 001000/001001 add with sign-extended imm; 001010 signed slt with sign-extended imm; 001011 unsigned slt with sign-extended imm; 001100 and, 001101 or, 001110 xor with zero-extended imm; 000100/000101 sub with b=rt_val; all other op 1111.
REQ-013 Operand a SHALL be rs_val except for shift-left; operand b SHALL be rt_val for R-type and branches, else extended imm.
REQ-014 The FSM SHALL have states IDLE, EXEC, DONE; reset state IDLE.
REQ-015 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; else 0.
REQ-016 On in_valid&in_ready the block SHALL register decoded control and operands and enter EXEC.
REQ-017 EXEC SHALL last exactly one cycle, capture the ALU result, zero and illegal into output registers, and enter DONE.
REQ-018 out_valid SHALL be 1 only in DONE; result/zero/illegal SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 In DONE with out_ready=1: if in_valid=1 the new instruction SHALL be accepted and the state SHALL go to EXEC, else to IDLE.
REQ-020 Latency from accept edge to out_valid SHALL be 2 cycles; back-to-back throughput SHALL be one result per 2 cycles.
REQ-021 Add/sub SHALL wrap modulo 2^32 with no overflow reporting; shift-left SHALL use only a[4:0].

Reset
REQ-022 On rst=1 at a clock edge, state SHALL go IDLE and out_valid, result, zero, illegal SHALL become 0 and alu_ctrl SHALL become 1111, regardless of current state, including mid-EXEC or DONE; the in-flight result SHALL be discarded.
REQ-023 in_ready SHALL be 0 during the reset cycle and 1 on the first cycle after rst deasserts.

Configuration
REQ-024 With ALU_ILLEGAL_TRAP_EN defined, illegal SHALL be 1 alongside out_valid for any decode yielding 1111, with result 0 and zero 1.
REQ-025 Without ALU_ILLEGAL_TRAP_EN, illegal SHALL be constant 0; undecodable instructions SHALL still complete with result 0 and zero 1.

Structure
REQ-026 A shared package alu_pkg SHALL hold the 4-bit control code constants, the opcode and funct constants, and the FSM state type.
REQ-027 Decoding SHALL be a combinational sub-module alu_decode (op, funct, shamt, imm, rs_val, rt_val to ctrl, a, b, illegal); the ALU datapath SHALL be instantiated as the team's existing ALU.

Verification
REQ-028 R-type add, rs=0x7FFFFFFF, rt=1 -> after 2 cycles out_valid=1, result 0x80000000, zero 0.
REQ-029 sll shamt=4, rt=0x0000000F -> result 0x000000F0; slti rs=0xFFFFFFFF, imm=0x0001 -> result 1; sltiu same operands -> result 0.
REQ-030 beq rs=rt=0x1234 -> result 0, zero 1; out_ready held 0 for 5 cycles -> outputs stable, in_ready 0.
REQ-031 Back-to-back: in DONE with out_ready=1 and in_valid=1 (ori rs=0xF0, imm=0x0F) -> accepted same cycle, next result 0xFF two cycles later.
REQ-032 op=111111 -> result 0, zero 1, illegal 1 with ALU_ILLEGAL_TRAP_EN, 0 without.
REQ-033 rst asserted during EXEC -> next cycle out_valid 0, result 0, alu_ctrl 1111, then in_ready 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue slice: control codes, MIPS opcode/funct values
// and the issue FSM state type.
package alu_pkg;

   // ALU control codes
   localparam logic [3:0] CtrlAdd  = 4'b0000;
   localparam logic [3:0] CtrlSub  = 4'b0001;
   localparam logic [3:0] CtrlSll  = 4'b0010;
   localparam logic [3:0] CtrlOr   = 4'b0011;
   localparam logic [3:0] CtrlAnd  = 4'b0100;
   localparam logic [3:0] CtrlSltu = 4'b0101;
   localparam logic [3:0] CtrlSlt  = 4'b0110;
   localparam logic [3:0] CtrlXor  = 4'b0111;
   localparam logic [3:0] CtrlNone = 4'b1111;

   // Opcodes
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAddiu = 6'b001001;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpSltiu = 6'b001011;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpXori  = 6'b001110;

   // R-type function codes
   localparam logic [5:0] FnSll  = 6'b000000;
   localparam logic [5:0] FnAdd  = 6'b100000;
   localparam logic [5:0] FnAddu = 6'b100001;
   localparam logic [5:0] FnSub  = 6'b100010;
   localparam logic [5:0] FnSubu = 6'b100011;
   localparam logic [5:0] FnAnd  = 6'b100100;
   localparam logic [5:0] FnOr   = 6'b100101;
   localparam logic [5:0] FnXor  = 6'b100110;
   localparam logic [5:0] FnSlt  = 6'b101010;
   localparam logic [5:0] FnSltu = 6'b101011;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/alu.sv
// 32-bit ALU datapath driven by a 4-bit control code.
module alu
   import alu_pkg::*;
(
   input  logic [3:0]  ctrl,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        zero
);

   // Select the operation; unknown codes yield 0
   always_comb begin
      case (ctrl)
         CtrlAdd:  result = a + b;
         CtrlSub:  result = a - b;
         CtrlSll:  result = b << a[4:0];
         CtrlOr:   result = a | b;
         CtrlAnd:  result = a & b;
         CtrlSltu: result = (a < b) ? 32'd1 : 32'd0;
         CtrlSlt:  result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         CtrlXor:  result = a ^ b;
         default:  result = 32'd0;
      endcase
   end

   assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_decode.sv
// Combinational MIPS decoder: selects ALU control code and operands.
// Optional feature macro: ALU_ILLEGAL_TRAP_EN (flag undecodable instructions as illegal).
module alu_decode
   import alu_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [3:0]  ctrl,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic        illegal
);

   logic [31:0] imm_sext;
   logic [31:0] imm_zext;

   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};

   // Decode control code and pick operand sources
   always_comb begin
      ctrl = CtrlNone;
      a    = rs_val;
      b    = imm_sext;
      if (op == OpRtype) begin
         b = rt_val;
         case (funct)
            FnAdd, FnAddu: ctrl = CtrlAdd;
            FnSub, FnSubu: ctrl = CtrlSub;
            FnSll: begin
               ctrl = CtrlSll;
               a    = {27'd0, shamt};
            end
            FnOr:    ctrl = CtrlOr;
            FnAnd:   ctrl = CtrlAnd;
            FnSlt:   ctrl = CtrlSlt;
            FnSltu:  ctrl = CtrlSltu;
            FnXor:   ctrl = CtrlXor;
            default: ctrl = CtrlNone;
         endcase
      end else begin
         case (op)
            OpAddi, OpAddiu: ctrl = CtrlAdd;
            OpSlti:          ctrl = CtrlSlt;
            OpSltiu:         ctrl = CtrlSltu;
            OpAndi: begin
               ctrl = CtrlAnd;
               b    = imm_zext;
            end
            OpOri: begin
               ctrl = CtrlOr;
               b    = imm_zext;
            end
            OpXori: begin
               ctrl = CtrlXor;
               b    = imm_zext;
            end
            OpBeq, OpBne: begin
               ctrl = CtrlSub;
               b    = rt_val;
            end
            default: ctrl = CtrlNone;
         endcase
      end
   end

`ifdef ALU_ILLEGAL_TRAP_EN
   assign illegal = (ctrl == CtrlNone);
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts one instruction, executes it for one cycle and holds the
// result under a valid/ready handshake. Optional macro: ALU_ILLEGAL_TRAP_EN.
module alu_issue
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        zero,
   output logic        illegal,
   output logic [3:0]  alu_ctrl
);

   state_e      state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        dec_ill_q, dec_ill_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d, illegal_q, illegal_d, out_valid_q, out_valid_d;

   logic [3:0]  dec_ctrl;
   logic [31:0] dec_a, dec_b, alu_res;
   logic        dec_ill, alu_zero, accept;

   alu_decode u_decode (
      .op      (op),
      .funct   (funct),
      .shamt   (shamt),
      .imm     (imm),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .ctrl    (dec_ctrl),
      .a       (dec_a),
      .b       (dec_b),
      .illegal (dec_ill)
   );

   alu u_alu (
      .ctrl   (ctrl_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_res),
      .zero   (alu_zero)
   );

   // Ready is suppressed during reset so nothing is accepted on the reset edge
   assign in_ready = ~rst & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
   assign accept   = in_valid & in_ready;

   // Next-state and output register updates
   always_comb begin
      state_d     = state_q;
      ctrl_d      = ctrl_q;
      a_d         = a_q;
      b_d         = b_q;
      dec_ill_d   = dec_ill_q;
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         ctrl_d    = dec_ctrl;
         a_d       = dec_a;
         b_d       = dec_b;
         dec_ill_d = dec_ill;
      end
      case (state_q)
         StIdle: if (accept) state_d = StExec;
         StExec: begin
            result_d    = alu_res;
            zero_d      = alu_zero;
            illegal_d   = dec_ill_q;
            out_valid_d = 1'b1;
            state_d     = StDone;
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = accept ? StExec : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ctrl_q      <= CtrlNone;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         dec_ill_q   <= 1'b0;
         result_q    <= 32'd0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         a_q         <= a_d;
         b_q         <= b_d;
         dec_ill_q   <= dec_ill_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
   assign alu_ctrl  = ctrl_q;

endmodule
